_cmp_lsbf_impl: RTL and testbench

Multi-cycle magnitude/equality comparator for the execute stage that scans operands LSB-first, one digit per cycle. This is the opposite direction to the single-cycle MSB-first compare. It resolves all six RISC-V branch/set conditions from funct3 and returns the codebase's all-ones/all-zeros mask (`aer`). It sits behind a valid/ready handshake so low-area configurations can trade latency for logic depth.

---
 rtl/_cmp_lsbf_impl.sv | 135 +++++++++++++
 tb/tb__cmp_lsbf_impl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/_cmp_lsbf_impl.sv
// _cmp_lsbf_impl: LSB-first multi-cycle comparator for branch/set conditions.
// Scans one DIGIT_W-bit digit per cycle; result is an all-ones/all-zeros mask.
module _cmp_lsbf_impl #(
    parameter int DIGIT_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] aer
);

    localparam int N  = 32 / DIGIT_W;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_EQ  = 3'b000;
    localparam logic [2:0] OP_NE  = 3'b001;
    localparam logic [2:0] OP_LT  = 3'b100;
    localparam logic [2:0] OP_GE  = 3'b101;
    localparam logic [2:0] OP_LTU = 3'b110;
    localparam logic [2:0] OP_GEU = 3'b111;

    logic [1:0]         state;
    logic [IW-1:0]      idx;
    logic               lt;
    logic               eq;
    logic [31:0]        ra;
    logic [31:0]        rb;
    logic [2:0]         rop;

    logic               last;
    logic               sgn;
    logic [31:0]        abias;
    logic [31:0]        bbias;
    logic [DIGIT_W-1:0] a_d;
    logic [DIGIT_W-1:0] b_d;
    logic               dig_ne;
    logic               lt_nx;
    logic               eq_nx;
    logic [31:0]        aer_nx;

    assign in_ready = (state == S_IDLE);

    // Digit select with sign-bias applied only on the MSB digit of signed ops
    always_comb begin
        last   = (idx == IW'(N - 1));
        sgn    = last && ((rop == OP_LT) || (rop == OP_GE));
        abias  = ra ^ {sgn, 31'b0};
        bbias  = rb ^ {sgn, 31'b0};
        a_d    = abias[idx*DIGIT_W +: DIGIT_W];
        b_d    = bbias[idx*DIGIT_W +: DIGIT_W];
        dig_ne = (a_d != b_d);
        lt_nx  = dig_ne ? (a_d < b_d) : lt;
        eq_nx  = eq & ~dig_ne;
    end

    // Map the final lt/eq flags onto the condition selected by funct3
    always_comb begin
        aer_nx = 32'h0;
        case (rop)
            OP_EQ:  aer_nx = {32{eq_nx}};
            OP_NE:  aer_nx = {32{~eq_nx}};
            OP_LT:  aer_nx = {32{lt_nx}};
            OP_LTU: aer_nx = {32{lt_nx}};
            OP_GE:  aer_nx = {32{~lt_nx}};
            OP_GEU: aer_nx = {32{~lt_nx}};
            default: aer_nx = 32'h0;
        endcase
    end

    // Control FSM and datapath state; flush aborts, higher digits override
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            lt        <= 1'b0;
            eq        <= 1'b1;
            ra        <= '0;
            rb        <= '0;
            rop       <= '0;
            out_valid <= 1'b0;
            aer       <= '0;
        end else if (flush) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        ra    <= a;
                        rb    <= b;
                        rop   <= op;
                        idx   <= '0;
                        lt    <= 1'b0;
                        eq    <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    lt <= lt_nx;
                    eq <= eq_nx;
                    if (last) begin
                        idx       <= '0;
                        aer       <= aer_nx;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb__cmp_lsbf_impl.sv
// tb__cmp_lsbf_impl: directed self-checking bench for _cmp_lsbf_impl.
// DIGIT_W=4, so results appear 8 cycles after the accept edge.
module tb__cmp_lsbf_impl;

    localparam int N = 8;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] aer;

    int passed;
    int total;

    _cmp_lsbf_impl #(.DIGIT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .aer       (aer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Accept one op, check latency and result, then consume it.
    task automatic do_op(input string tag, input logic [31:0] av,
                         input logic [31:0] bv, input logic [2:0] ov,
                         input logic [31:0] exp);
        @(negedge clk);
        chk({tag, "_inrdy"}, {31'b0, in_ready}, 32'd1);
        a = av;
        b = bv;
        op = ov;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int k = 1; k <= N; k++) begin
            @(posedge clk);
            #1;
            if (k == N - 1)
                chk({tag, "_early"}, {31'b0, out_valid}, 32'd0);
        end
        chk({tag, "_ov"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_aer"}, aer, exp);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_drop"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        logic       seen;
        logic [31:0] held;
        passed = 0;
        total = 0;
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        op = '0;
        out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ov", {31'b0, out_valid}, 32'd0);
        chk("rst_aer", aer, 32'h0);
        chk("rst_inrdy", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        do_op("geu", 32'h8000_0000, 32'h7FFF_FFFF, 3'b111, 32'hFFFF_FFFF);
        do_op("lt", 32'h8000_0000, 32'h7FFF_FFFF, 3'b100, 32'hFFFF_FFFF);
        do_op("ltu", 32'h8000_0000, 32'h7FFF_FFFF, 3'b110, 32'h0);
        do_op("ge", 32'h8000_0000, 32'h7FFF_FFFF, 3'b101, 32'h0);
        do_op("eq_same", 32'h1234_5678, 32'h1234_5678, 3'b000, 32'hFFFF_FFFF);
        do_op("ne_same", 32'h1234_5678, 32'h1234_5678, 3'b001, 32'h0);
        do_op("eq_diff", 32'h1234_5678, 32'h1234_5679, 3'b000, 32'h0);
        do_op("ne_diff", 32'h1234_5678, 32'h1234_5679, 3'b001, 32'hFFFF_FFFF);
        do_op("override", 32'h1000_000F, 32'h0FFF_FFF0, 3'b110, 32'h0);
        do_op("lt_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3'b100, 32'h0);
        do_op("ge_neg", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 3'b101, 32'h0);
        do_op("ltu_low", 32'h0000_0001, 32'h0000_0002, 3'b110, 32'hFFFF_FFFF);
        do_op("rsvd", 32'h0000_0001, 32'h0000_0002, 3'b010, 32'h0);

        // Backpressure: result must hold, no second accept
        @(negedge clk);
        a = 32'h1;
        b = 32'h2;
        op = 3'b110;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        a = 32'h5;
        b = 32'h3;
        repeat (N) @(posedge clk);
        #1;
        chk("bp_ov", {31'b0, out_valid}, 32'd1);
        held = aer;
        chk("bp_aer", held, 32'hFFFF_FFFF);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_aer", aer, 32'hFFFF_FFFF);
            chk("bp_hold_rdy", {31'b0, in_ready}, 32'd0);
            chk("bp_hold_ov", {31'b0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_idle_ov", {31'b0, out_valid}, 32'd0);
        chk("bp_idle_rdy", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_accept2", {31'b0, in_ready}, 32'd0);
        repeat (N) @(posedge clk);
        #1;
        chk("bp2_ov", {31'b0, out_valid}, 32'd1);
        chk("bp2_aer", aer, 32'h0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Flush wins over in_valid in IDLE
        @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_idle_rdy", {31'b0, in_ready}, 32'd1);

        // Flush mid-RUN at idx=3
        @(negedge clk);
        a = 32'h0;
        b = 32'h1;
        op = 3'b000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_rdy", {31'b0, in_ready}, 32'd1);
        seen = 1'b0;
        for (int k = 0; k < N + 2; k++) begin
            @(posedge clk);
            #1;
            seen = seen | out_valid;
        end
        chk("flush_no_ov", {31'b0, seen}, 32'd0);
        do_op("post_flush", 32'h0000_0003, 32'h0000_0003, 3'b000, 32'hFFFF_FFFF);

        // Asynchronous reset mid-RUN
        @(negedge clk);
        a = 32'h0;
        b = 32'h1;
        op = 3'b110;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ov", {31'b0, out_valid}, 32'd0);
        chk("arst_rdy", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < N + 2; k++) begin
            @(posedge clk);
            #1;
            seen = seen | out_valid;
        end
        chk("arst_no_ov", {31'b0, seen}, 32'd0);
        do_op("post_rst", 32'h7FFF_FFFF, 32'h8000_0000, 3'b101, 32'hFFFF_FFFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
